// File: rtl/spi_pkt_pkg.sv
// Shared constants and types for the SPI command-packet decoder.
package spi_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_WR_INC = 8'h01;
  localparam logic [7:0] CMD_WR_FIX = 8'h02;

  typedef enum logic [1:0] {
    ERR_BAD_CMD  = 2'd0,
    ERR_BAD_LEN  = 2'd1,
    ERR_CHECKSUM = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_LEN    = 3'd3,
    ST_DATA   = 3'd4,
    ST_CHK    = 3'd5,
    ST_COMMIT = 3'd6
  } pkt_state_t;

  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    return (cmd == CMD_WR_INC) || (cmd == CMD_WR_FIX);
  endfunction

endpackage

// File: rtl/spi_pkt_buffer.sv
// Payload staging RAM: written during DATA, read back while committing.
module spi_pkt_buffer #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data_c
);

  logic [7:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/spi_pkt_decoder.sv
// Frames SPI bytes into SYNC/CMD/ADDR/LEN/DATA packets and issues byte writes.
// Define SPI_PKT_CHECKSUM_EN to add the CHK byte, payload buffering and COMMIT.
module spi_pkt_decoder
  import spi_pkt_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              pkt_ok,
  output logic              pkt_err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [7:0]        pkt_cnt
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  pkt_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              inc_q, inc_d;
  logic [TMO_W-1:0]  tmo_q;

  logic              wr_en_d, ok_d, err_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;
  err_code_t         code_d;
  logic              timed;
  logic              last;

`ifdef SPI_PKT_CHECKSUM_EN
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [7:0] xor_q, xor_d;
  logic       buf_we;
  logic [7:0] buf_rd_data;

  spi_pkt_buffer #(
    .DEPTH (MAX_LEN)
  ) u_buffer (
    .clk       (clk),
    .we        (buf_we),
    .wr_idx    (IDX_W'(cnt_q)),
    .wr_data   (byte_in),
    .rd_idx    (IDX_W'(cnt_q)),
    .rd_data_c (buf_rd_data)
  );
`endif

  assign timed = (state_q != ST_IDLE) && (state_q != ST_COMMIT);
  assign last  = (cnt_q == (len_q - LEN_W'(1)));

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
`ifdef SPI_PKT_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
`ifdef SPI_PKT_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  // Inter-byte idle counter, only meaningful while a packet is being received
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else if (!timed || byte_valid) begin
      tmo_q <= '0;
    end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    inc_d     = inc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = addr_q;
    wr_data_d = byte_in;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = ERR_BAD_CMD;
`ifdef SPI_PKT_CHECKSUM_EN
    xor_d     = xor_q;
    buf_we    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (byte_valid && (byte_in == SYNC_BYTE)) state_d = ST_CMD;
      end

      ST_CMD: begin
        if (byte_valid) begin
          if (cmd_is_valid(byte_in)) begin
            inc_d   = (byte_in == CMD_WR_INC);
            state_d = ST_ADDR;
`ifdef SPI_PKT_CHECKSUM_EN
            xor_d   = byte_in;
`endif
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_CMD;
            state_d = ST_IDLE;
          end
        end
      end

      ST_ADDR: begin
        if (byte_valid) begin
          addr_d  = ADDR_W'(byte_in);
          state_d = ST_LEN;
`ifdef SPI_PKT_CHECKSUM_EN
          xor_d   = xor_q ^ byte_in;
`endif
        end
      end

      ST_LEN: begin
        if (byte_valid) begin
          if (32'(byte_in) > MAX_LEN) begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_LEN;
            state_d = ST_IDLE;
          end else begin
            len_d = LEN_W'(byte_in);
            cnt_d = '0;
`ifdef SPI_PKT_CHECKSUM_EN
            xor_d   = xor_q ^ byte_in;
            state_d = (byte_in == 8'h00) ? ST_CHK : ST_DATA;
`else
            if (byte_in == 8'h00) begin
              ok_d    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
            end
`endif
          end
        end
      end

      ST_DATA: begin
        if (byte_valid) begin
`ifdef SPI_PKT_CHECKSUM_EN
          // Stage only; writes wait until the checksum has been verified
          buf_we = 1'b1;
          xor_d  = xor_q ^ byte_in;
          if (last) begin
            cnt_d   = '0;
            state_d = ST_CHK;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
`else
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = byte_in;
          if (inc_q) addr_d = addr_q + ADDR_W'(1);
          cnt_d = cnt_q + LEN_W'(1);
          if (last) begin
            ok_d    = 1'b1;
            state_d = ST_IDLE;
          end
`endif
        end
      end

`ifdef SPI_PKT_CHECKSUM_EN
      ST_CHK: begin
        if (byte_valid) begin
          if (byte_in != xor_q) begin
            err_d   = 1'b1;
            code_d  = ERR_CHECKSUM;
            state_d = ST_IDLE;
          end else if (len_q == LEN_W'(0)) begin
            ok_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // First buffered write goes out on the cycle right after CHK
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = buf_rd_data;
            if (inc_q) addr_d = addr_q + ADDR_W'(1);
            cnt_d = cnt_q + LEN_W'(1);
            if (len_q == LEN_W'(1)) begin
              ok_d    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_COMMIT;
            end
          end
        end
      end

      ST_COMMIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = buf_rd_data;
        if (inc_q) addr_d = addr_q + ADDR_W'(1);
        cnt_d = cnt_q + LEN_W'(1);
        if (last) begin
          ok_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // A byte arriving on the expiry cycle wins over the abort
    if (timed && !byte_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
      state_d = ST_IDLE;
      wr_en_d = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= 2'd0;
      busy     <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      wr_en   <= wr_en_d;
      pkt_ok  <= ok_d;
      pkt_err <= err_d;
      busy    <= (state_d != ST_IDLE);
      if (wr_en_d) begin
        wr_addr <= wr_addr_d;
        wr_data <= wr_data_d;
      end
      if (err_d) err_code <= code_d;
      if (ok_d)  pkt_cnt  <= pkt_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_pkt_decoder.sv
// Scoreboard bench for spi_pkt_decoder; follows SPI_PKT_CHECKSUM_EN if defined.
module tb_spi_pkt_decoder;

  localparam int unsigned TMO = 300;
  localparam int unsigned GAP = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       pkt_ok;
  logic       pkt_err;
  logic [1:0] err_code;
  logic       busy;
  logic [7:0] pkt_cnt;

  always #5 clk = ~clk;

  spi_pkt_decoder #(
    .ADDR_W         (8),
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pkt_ok     (pkt_ok),
    .pkt_err    (pkt_err),
    .err_code   (err_code),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt)
  );

  typedef enum logic [1:0] {EV_WR, EV_OK, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] code;
    logic [7:0] cnt;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] pay [16];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL unexpected_%s: got pulse, required none (t=%0t)", name, $time);
  endtask

  function automatic bit next_is(input ev_kind_e k);
    return (exp_q.size() != 0) && (exp_q[0].kind == k);
  endfunction

  function automatic ev_t mk(input ev_kind_e k, input logic [7:0] a, input logic [7:0] d,
                             input logic [1:0] c, input logic [7:0] n);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.code = c; e.cnt = n;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an event
  always @(negedge clk) begin
    if (reset_n) begin
      if (pkt_ok && pkt_err) unexpected("ok_with_err");
      if (wr_en) begin
        if (next_is(EV_WR)) begin
          mon_e = exp_q.pop_front();
          check8("wr_addr", wr_addr, mon_e.addr);
          check8("wr_data", wr_data, mon_e.data);
        end else unexpected("wr_en");
      end
      if (pkt_ok) begin
        if (next_is(EV_OK)) begin
          mon_e = exp_q.pop_front();
          check8("pkt_cnt", pkt_cnt, mon_e.cnt);
        end else unexpected("pkt_ok");
      end
      if (pkt_err) begin
        if (next_is(EV_ERR)) begin
          mon_e = exp_q.pop_front();
          check8("err_code", {6'd0, err_code}, {6'd0, mon_e.code});
        end else unexpected("pkt_err");
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (GAP - 2) @(negedge clk);
  endtask

  // Full packet from pay[]; expectations pushed before any byte goes out
  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] addr,
                          input logic [7:0] len, input bit corrupt);
    logic [7:0] a;
    logic [7:0] x;
    a = addr;
    x = cmd ^ addr ^ len;
    for (int i = 0; i < int'(len); i++) x = x ^ pay[i];
`ifdef SPI_PKT_CHECKSUM_EN
    if (corrupt) begin
      exp_q.push_back(mk(EV_ERR, 8'd0, 8'd0, 2'd2, 8'd0));
    end else
`endif
    begin
      for (int i = 0; i < int'(len); i++) begin
        exp_q.push_back(mk(EV_WR, a, pay[i], 2'd0, 8'd0));
        if (cmd == 8'h01) a = a + 8'd1;
      end
      exp_cnt = exp_cnt + 8'd1;
      exp_q.push_back(mk(EV_OK, 8'd0, 8'd0, 2'd0, exp_cnt));
    end
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(addr);
    send_byte(len);
    for (int i = 0; i < int'(len); i++) send_byte(pay[i]);
`ifdef SPI_PKT_CHECKSUM_EN
    send_byte(corrupt ? (x ^ 8'h5A) : x);
`else
    if (corrupt || (x == 8'h00)) @(negedge clk);
`endif
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check8(name, 8'(exp_q.size()), 8'd0);
    exp_q.delete();
  endtask

  initial begin
    #(400_000);
    $display("FAIL watchdog: got no end of test, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check8("rst_wr_en",    {7'd0, wr_en},    8'd0);
    check8("rst_pkt_ok",   {7'd0, pkt_ok},   8'd0);
    check8("rst_pkt_err",  {7'd0, pkt_err},  8'd0);
    check8("rst_err_code", {6'd0, err_code}, 8'd0);
    check8("rst_busy",     {7'd0, busy},     8'd0);
    check8("rst_pkt_cnt",  pkt_cnt,          8'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Non-sync bytes in IDLE are dropped silently
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check8("idle_drop_busy", {7'd0, busy}, 8'd0);

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_pkt(8'h01, 8'h10, 8'd3, 1'b0);
    drain("drain_inc");

    pay[0] = 8'hAA; pay[1] = 8'hBB;
    send_pkt(8'h02, 8'h40, 8'd2, 1'b0);
    drain("drain_fix");

`ifdef SPI_PKT_CHECKSUM_EN
    pay[0] = 8'h55;
    send_pkt(8'h01, 8'h10, 8'd1, 1'b1);
    drain("drain_bad_chk");
`endif

    exp_q.push_back(mk(EV_ERR, 8'd0, 8'd0, 2'd0, 8'd0));
    send_byte(8'hA5);
    send_byte(8'h07);
    drain("drain_bad_cmd");
    check8("bad_cmd_busy", {7'd0, busy}, 8'd0);

    exp_q.push_back(mk(EV_ERR, 8'd0, 8'd0, 2'd1, 8'd0));
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    drain("drain_bad_len");

    for (int i = 0; i < 16; i++) pay[i] = 8'(i * 7 + 1);
    send_pkt(8'h01, 8'h80, 8'd16, 1'b0);
    drain("drain_len16");

    pay[0] = 8'h01; pay[1] = 8'h02;
    send_pkt(8'h01, 8'hFF, 8'd2, 1'b0);
    drain("drain_wrap");

    send_pkt(8'h01, 8'h20, 8'd0, 1'b0);
    drain("drain_len0");

    // Stall mid-packet until the idle timeout aborts it
    exp_q.push_back(mk(EV_ERR, 8'd0, 8'd0, 2'd3, 8'd0));
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    check8("stall_busy", {7'd0, busy}, 8'd1);
    repeat (TMO + 40) @(negedge clk);
    drain("drain_timeout");
    check8("timeout_busy", {7'd0, busy}, 8'd0);

    pay[0] = 8'h99; pay[1] = 8'h66;
    send_pkt(8'h01, 8'h30, 8'd2, 1'b0);
    drain("drain_after_tmo");

    // Reset mid-packet: no writes, no pulses, counter cleared
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h02);
    check8("pre_reset_busy", {7'd0, busy}, 8'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check8("mid_reset_busy", {7'd0, busy}, 8'd0);
    check8("mid_reset_cnt",  pkt_cnt,      8'd0);
    exp_cnt = 8'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * GAP) @(negedge clk);
    check8("post_reset_quiet", 8'(exp_q.size()), 8'd0);

    pay[0] = 8'hC3;
    send_pkt(8'h02, 8'h05, 8'd1, 1'b0);
    drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
